// File: rtl/aes_inv_sub_bytes.sv
// ---------------------------------------------------------------------------
// aes_inv_sub_bytes
//   Sequential InvSubBytes engine for the AES inverse-cipher round path.
//   A 128-bit state is taken over a valid/ready handshake. LANES bytes are
//   substituted through the inverse S-box per cycle, so a block needs
//   16/LANES SUB cycles. The result is then held on a valid/ready output.
//   Byte k of a state is data[127-8k -: 8]. State (row r, col c) is byte r+4c.
//
// Parameters
//   LANES    inverse S-box instances (bytes per cycle): 1, 2, 4, 8 or 16
//
// Optional build macro
//   AES_INV_SHIFTROWS_EN  fuse InvShiftRows onto the result on its way into
//                         OUT. Row r is rotated right by r. Latency does not
//                         change.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset; aborts any block in flight
//   s_valid  in   input state valid
//   s_ready  out  engine can accept a state (IDLE, not in or just out of rst)
//   s_data   in   128-bit input state
//   m_valid  out  result valid (OUT state)
//   m_ready  in   downstream accepts result
//   m_data   out  128-bit result, held until the next result or reset
//   busy     out  high in SUB or OUT
// ---------------------------------------------------------------------------
module aes_inv_sub_bytes #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16))
  begin : g_bad_lanes
    $error("aes_inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int unsigned GROUPS = 16 / LANES;
  localparam int unsigned CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE, SUB, OUT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_rdy_en;   // 0 in reset, 1 from the first edge after release
  logic [127:0]  r_work;
  logic [127:0]  r_mdata;
  logic [127:0]  w_sub;
  logic [127:0]  w_result;
  logic          w_accept;
  logic          w_last;

`ifdef AES_INV_SHIFTROWS_EN
  // out(r,c) = in(r,(c-r) mod 4): row r rotated right by r positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] d);
    logic [127:0] o;
    o = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        o[127 - 8*(r + 4*c) -: 8] = d[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
      end
    end
    return o;
  endfunction
`endif

  assign w_accept = s_valid && s_ready;
  assign w_last   = (r_cnt == LAST);

  // Substitute the current group of LANES bytes; all other bytes pass through.
  always_comb begin
    w_sub = r_work;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_sub[127 - 8*(32'(r_cnt)*LANES + l) -: 8] =
        INV_SBOX[r_work[127 - 8*(32'(r_cnt)*LANES + l) -: 8]];
    end
  end

  always_comb begin
`ifdef AES_INV_SHIFTROWS_EN
    w_result = w_last ? inv_shift_rows(w_sub) : w_sub;
`else
    w_result = w_sub;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SUB;
      SUB:     if (w_last)   w_state_nxt = OUT;
      OUT:     if (m_ready)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: decoded from registered state only
  always_comb begin
    s_ready = (r_state == IDLE) && r_rdy_en;
    m_valid = (r_state == OUT);
    busy    = (r_state != IDLE);
  end

  // Datapath. m_data has its own register so it stays put while the next
  // block is captured and substituted in r_work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy_en <= 1'b0;
      r_cnt    <= '0;
      r_work   <= '0;
      r_mdata  <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_accept) r_work <= s_data;
        end
        SUB: begin
          r_work <= w_result;
          if (w_last) begin
            r_cnt   <= '0;
            r_mdata <= w_result;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign m_data = r_mdata;

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
module tb_aes_inv_sub_bytes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LANES=4 instance
  logic         rst, s_valid, s_ready, m_valid, m_ready, busy;
  logic [127:0] s_data, m_data;
  // LANES=1 instance
  logic         rst1, s1_valid, s1_ready, m1_valid, m1_ready, busy1;
  logic [127:0] s1_data, m1_data;

  aes_inv_sub_bytes #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  aes_inv_sub_bytes #(.LANES(1)) u_dut1 (
    .clk(clk), .rst(rst1), .s_valid(s1_valid), .s_ready(s1_ready), .s_data(s1_data),
    .m_valid(m1_valid), .m_ready(m1_ready), .m_data(m1_data), .busy(busy1)
  );

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  logic [7:0] fwd_sb [256];
  logic [7:0] inv_sb [256];

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
    string        name;
  } vec_t;
  vec_t tbl [$];

  // ---------------- reference model (GF(2^8) arithmetic) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v};
    return t[15-n -: 8];
  endfunction

  task automatic build_tables();
    logic [7:0] b, s;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      fwd_sb[x] = s;
    end
    for (int x = 0; x < 256; x++) inv_sb[fwd_sb[x]] = 8'(x);
  endtask

  function automatic logic [7:0] getb(input logic [127:0] d, input int k);
    return d[127 - 8*k -: 8];
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] din);
    logic [7:0] sub [16];
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) sub[k] = inv_sb[getb(din, k)];
`ifdef AES_INV_SHIFTROWS_EN
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8*(r + 4*((c + r) % 4)) -: 8] = sub[r + 4*c];
`else
    for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = sub[k];
`endif
    return o;
  endfunction

  // Apply the forward S-box to a result and put bytes back where they came from.
  function automatic logic [127:0] fwd_undo(input logic [127:0] res);
    logic [127:0] o;
    int src;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
`ifdef AES_INV_SHIFTROWS_EN
        src = r + 4*((c - r + 4) % 4);
`else
        src = r + 4*c;
`endif
        o[127 - 8*src -: 8] = fwd_sb[getb(res, r + 4*c)];
      end
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One full block through the LANES=4 engine with m_ready held low until m_valid.
  task automatic run4(input logic [127:0] din, input logic [127:0] exp, input string name);
    int lat, w;
    @(negedge clk);
    w = 0;
    while (!s_ready && w < 50) begin @(negedge clk); w++; end
    check({name, "_rdy"}, 128'(s_ready), 128'(1));
    s_valid = 1'b1; s_data = din; m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0; s_data = ~din;
    lat = 0;
    while (!m_valid && lat < 40) begin @(negedge clk); lat++; end
    check({name, "_lat"}, 128'(lat), 128'(4));
    check({name, "_data"}, m_data, exp);
    check({name, "_fwd"}, fwd_undo(m_data), din);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic run1(input logic [127:0] din, input string name);
    int lat, w;
    @(negedge clk);
    w = 0;
    while (!s1_ready && w < 50) begin @(negedge clk); w++; end
    s1_valid = 1'b1; s1_data = din; m1_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s1_valid = 1'b0;
    lat = 0;
    while (!m1_valid && lat < 60) begin @(negedge clk); lat++; end
    check({name, "_lat"}, 128'(lat), 128'(16));
    check({name, "_data"}, m1_data, ref_block(din));
    m1_ready = 1'b1;
    @(negedge clk);
    m1_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] a, b, d, e, blk;
    int first, second, w, hits;

    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    rst1 = 1'b1; s1_valid = 1'b0; m1_ready = 1'b0; s1_data = '0;
    build_tables();

    // ---- table of vectors ----
    tbl.push_back('{128'h63636363_63636363_63636363_63636363, 128'h0, "all63"});
`ifdef AES_INV_SHIFTROWS_EN
    tbl.push_back('{128'h637c6363_63636363_63636363_63636363,
                    128'h00000000_00010000_00000000_00000000, "b1_7c"});
`else
    tbl.push_back('{128'h637c6363_63636363_63636363_63636363,
                    128'h00010000_00000000_00000000_00000000, "b1_7c"});
`endif
    tbl.push_back('{128'h0, {16{8'h52}}, "all00"});
    tbl.push_back('{{16{8'h16}}, {16{8'hff}}, "all16"});
    for (int j = 0; j < 16; j++) begin
      blk = '0;
      for (int k = 0; k < 16; k++) blk[127 - 8*k -: 8] = 8'(16*j + k);
      tbl.push_back('{blk, ref_block(blk), $sformatf("exh%0d", j)});
    end
    for (int j = 0; j < 8; j++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      tbl.push_back('{blk, ref_block(blk), $sformatf("rnd%0d", j)});
    end

    // ---- reset values ----
    repeat (2) @(negedge clk);
    check("rst_s_ready", 128'(s_ready), 128'(0));
    check("rst_m_valid", 128'(m_valid), 128'(0));
    check("rst_m_data", m_data, 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0; rst1 = 1'b0;
    #1 check("rel_pre_edge", 128'(s_ready), 128'(0));
    @(negedge clk);
    check("rel_post_edge", 128'(s_ready), 128'(1));

    // ---- table-driven blocks ----
    foreach (tbl[i]) run4(tbl[i].din, tbl[i].exp, tbl[i].name);

    // ---- minimum block period, m_ready and s_valid held high ----
    d = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    s_valid = 1'b1; s_data = d; m_ready = 1'b1;
    first = -1; second = -1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (m_valid) begin
        if (first < 0) begin
          first = i;
          check("period_data", m_data, ref_block(d));
        end else if (second < 0) second = i;
      end
    end
    check("period_first", 128'(first), 128'(4));
    check("period_gap", 128'(second - first), 128'(6));
    s_valid = 1'b0;
    w = 0;
    while (busy && w < 20) begin @(negedge clk); w++; end
    check("period_drain", 128'(busy), 128'(0));
    m_ready = 1'b0;

    // ---- backpressure ----
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    e = ref_block(a);
    @(negedge clk);
    s_valid = 1'b1; s_data = a;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    w = 0;
    while (!m_valid && w < 40) begin @(negedge clk); w++; end
    check("bp_lat", 128'(w), 128'(4));
    s_valid = 1'b1; s_data = b;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_ctl%0d", i), 128'({m_valid, s_ready, busy}), 128'(3'b101));
      check($sformatf("bp_data%0d", i), m_data, e);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("bp_idle_ctl", 128'({m_valid, s_ready, busy}), 128'(3'b010));
    check("bp_idle_data", m_data, e);
    @(negedge clk);
    s_valid = 1'b0;
    check("bp_acc_ctl", 128'({m_valid, s_ready, busy}), 128'(3'b001));
    check("bp_acc_keep", m_data, e);
    w = 0;
    while (!m_valid && w < 40) begin @(negedge clk); w++; end
    check("bp2_lat", 128'(w), 128'(4));
    check("bp2_data", m_data, ref_block(b));

    // ---- reset mid-SUB (LANES=4) while holding a nonzero result ----
    @(negedge clk);
    s_valid = 1'b1; s_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 check("rstmid_ctl", 128'({m_valid, s_ready, busy}), 128'(0));
    check("rstmid_data", m_data, 128'(0));
    @(negedge clk);
    check("rstmid_hold_ctl", 128'({m_valid, s_ready, busy}), 128'(0));
    rst = 1'b0;
    #1 check("rstmid_rel_pre", 128'(s_ready), 128'(0));
    @(negedge clk);
    check("rstmid_rel_post", 128'({m_valid, s_ready, busy}), 128'(3'b010));
    hits = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (m_valid || busy) hits++; end
    check("rstmid_no_out", 128'(hits), 128'(0));
    run4(128'h637c6363_63636363_63636363_63636363, tbl[1].exp, "post_rst");

    // ---- LANES=1: normal block, then abort at SUB cycle 7 ----
    run1({$urandom, $urandom, $urandom, $urandom}, "l1_a");
    @(negedge clk);
    s1_valid = 1'b1; s1_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    s1_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("l1_mid_busy", 128'(busy1), 128'(1));
    rst1 = 1'b1;
    #1 check("l1_rst_ctl", 128'({m1_valid, s1_ready, busy1}), 128'(0));
    check("l1_rst_data", m1_data, 128'(0));
    @(negedge clk);
    rst1 = 1'b0;
    hits = 0;
    for (int i = 0; i < 25; i++) begin @(negedge clk); if (m1_valid) hits++; end
    check("l1_no_out", 128'(hits), 128'(0));
    run1({$urandom, $urandom, $urandom, $urandom}, "l1_b");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
